// File: rtl/conv_pass_sched_if.sv
// Layer configuration and pixel-stream handshake between the conv front end and the pass scheduler.
interface conv_pass_sched_if #(
  parameter int ROW_BUFFER_DEPTH = 9,
  parameter int GRP_WIDTH        = 6
);
  logic                        start;
  logic [1:0]                  cfg_mode;
  logic [ROW_BUFFER_DEPTH-1:0] cfg_row_len;
  logic [ROW_BUFFER_DEPTH-1:0] cfg_rows;
  logic [GRP_WIDTH-1:0]        cfg_ic_grp;
  logic [GRP_WIDTH-1:0]        cfg_oc_grp;
  logic                        pix_valid;
  logic                        pix_ready;

  modport master (
    output start, cfg_mode, cfg_row_len, cfg_rows, cfg_ic_grp, cfg_oc_grp, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  start, cfg_mode, cfg_row_len, cfg_rows, cfg_ic_grp, cfg_oc_grp, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/conv_pass_sched.sv
// Pass scheduler for the 3x3 conv unit: one pass per (oc group, ic group); start->CFG in 1 cycle, strobes at transfer+1/+1+M/+2+M.
// Backpressure: pix_ready only in RUN; pix_valid stalls freeze position counters while strobe delay lines keep shifting.
module conv_pass_sched #(
  parameter int ROW_BUFFER_DEPTH    = 9,
  parameter int GRP_WIDTH           = 6,
  parameter int MULT_PIPELINE_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        state_rst,
  conv_pass_sched_if.slave            bus,
  output logic [2:0]                  current_state,
  output logic [ROW_BUFFER_DEPTH-1:0] buff_len_ctrl,
  output logic                        buff_len_rst,
  output logic                        win_valid,
  output logic                        adder_rst,
  output logic                        out_valid,
  output logic [GRP_WIDTH-1:0]        ic_idx,
  output logic [GRP_WIDTH-1:0]        oc_idx,
  output logic                        busy,
  output logic                        done
);
  localparam int RW = ROW_BUFFER_DEPTH;
  localparam int GW = GRP_WIDTH;
  localparam int M  = MULT_PIPELINE_STAGE;
  localparam int DW = $clog2(M + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          abort;
  logic          cfg_ok;
  logic          xfer;
  logic          pass_end;
  logic          more_ic;
  logic          more_oc;
  logic          win_px;
  logic [1:0]    mode;
  logic [RW-1:0] row_len;
  logic [RW-1:0] rows;
  logic [RW-1:0] col;
  logic [RW-1:0] row;
  logic [GW-1:0] ic_grp;
  logic [GW-1:0] oc_grp;
  logic [DW-1:0] drain_cnt;
  logic [M:0]    adr_pipe;
  logic [M+1:0]  out_pipe;

  assign abort    = rst | state_rst;
  assign cfg_ok   = (bus.cfg_row_len >= RW'(3)) && (bus.cfg_rows >= RW'(3)) &&
                    (bus.cfg_ic_grp != '0) && (bus.cfg_oc_grp != '0);
  assign xfer     = (state == S_RUN) && bus.pix_valid;
  assign pass_end = xfer && (col == row_len - RW'(1)) && (row == rows - RW'(1));
  assign more_ic  = ic_idx != ic_grp - GW'(1);
  assign more_oc  = oc_idx != oc_grp - GW'(1);
  assign win_px   = xfer && (row >= RW'(2)) && (col >= RW'(2));

  assign buff_len_ctrl = row_len;
  assign adder_rst     = adr_pipe[M];
  assign out_valid     = out_pipe[M+1];

  always_ff @(posedge clk) begin
    if (abort) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start && cfg_ok) state_nxt = S_CFG;
      S_CFG:   state_nxt = S_RUN;
      S_RUN:   if (pass_end) state_nxt = (more_ic || more_oc) ? S_CFG : S_DRAIN;
      S_DRAIN: if (drain_cnt == DW'(M + 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready = (state == S_RUN);
    buff_len_rst  = (state == S_CFG);
    busy          = (state == S_CFG) || (state == S_RUN) || (state == S_DRAIN);
    done          = (state == S_DONE);
    current_state = busy ? {1'b0, mode} : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      mode      <= '0;
      row_len   <= '0;
      rows      <= '0;
      ic_grp    <= '0;
      oc_grp    <= '0;
      col       <= '0;
      row       <= '0;
      ic_idx    <= '0;
      oc_idx    <= '0;
      drain_cnt <= '0;
      win_valid <= 1'b0;
      adr_pipe  <= '0;
      out_pipe  <= '0;
    end else begin
      if (state == S_IDLE && bus.start && cfg_ok) begin
        // mode 0 is run as mode A
        mode    <= (bus.cfg_mode == 2'd0) ? 2'd1 : bus.cfg_mode;
        row_len <= bus.cfg_row_len;
        rows    <= bus.cfg_rows;
        ic_grp  <= bus.cfg_ic_grp;
        oc_grp  <= bus.cfg_oc_grp;
      end

      if (state == S_CFG) begin
        col <= '0;
        row <= '0;
      end else if (xfer) begin
        if (col == row_len - RW'(1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + RW'(1);
        end
      end

      if (pass_end) begin
        if (more_ic) begin
          ic_idx <= ic_idx + GW'(1);
        end else if (more_oc) begin
          ic_idx <= '0;
          oc_idx <= oc_idx + GW'(1);
        end
      end else if (state == S_DONE) begin
        ic_idx <= '0;
        oc_idx <= '0;
      end

      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;

      // delay lines run every cycle so in-flight strobes are unaffected by stalls
      win_valid <= win_px;
      adr_pipe  <= {adr_pipe[M-1:0], win_px && (ic_idx == '0)};
      out_pipe  <= {out_pipe[M:0], win_px && !more_ic};
    end
  end
endmodule

// File: tb/tb_conv_pass_sched.sv
// Randomized bench for conv_pass_sched: per-cycle comparison against a pass-level schedule model.
module tb_conv_pass_sched;
  localparam int RW   = 9;
  localparam int GW   = 6;
  localparam int M    = 2;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          state_rst;
  logic [2:0]    current_state;
  logic [RW-1:0] buff_len_ctrl;
  logic          buff_len_rst, win_valid, adder_rst, out_valid, busy, done;
  logic [GW-1:0] ic_idx, oc_idx;

  conv_pass_sched_if #(.ROW_BUFFER_DEPTH(RW), .GRP_WIDTH(GW)) bus ();

  conv_pass_sched #(
    .ROW_BUFFER_DEPTH(RW), .GRP_WIDTH(GW), .MULT_PIPELINE_STAGE(M)
  ) dut (
    .clk(clk), .rst(rst), .state_rst(state_rst), .bus(bus),
    .current_state(current_state), .buff_len_ctrl(buff_len_ctrl),
    .buff_len_rst(buff_len_rst), .win_valid(win_valid), .adder_rst(adder_rst),
    .out_valid(out_valid), .ic_idx(ic_idx), .oc_idx(oc_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // expected per-cycle outputs of one layer run, cycle 0 = cycle start is presented
  bit e_rdy[MAXC], e_br[MAXC], e_win[MAXC], e_adr[MAXC], e_out[MAXC], e_busy[MAXC], e_done[MAXC];
  int e_st[MAXC], e_ic[MAXC], e_oc[MAXC], e_blc[MAXC];
  bit pv[MAXC];
  int blc_prev = 0;
  int c_x, c_win, c_adr, c_out, c_br, last_x, done_at;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_cycle(input int k);
    check($sformatf("pix_ready@%0d", k), 32'(bus.pix_ready), 32'(e_rdy[k]));
    check($sformatf("state@%0d", k), 32'(current_state), 32'(e_st[k]));
    check($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy[k]));
    check($sformatf("done@%0d", k), 32'(done), 32'(e_done[k]));
    check($sformatf("buff_len_rst@%0d", k), 32'(buff_len_rst), 32'(e_br[k]));
    check($sformatf("buff_len_ctrl@%0d", k), 32'(buff_len_ctrl), 32'(e_blc[k]));
    check($sformatf("win_valid@%0d", k), 32'(win_valid), 32'(e_win[k]));
    check($sformatf("adder_rst@%0d", k), 32'(adder_rst), 32'(e_adr[k]));
    check($sformatf("out_valid@%0d", k), 32'(out_valid), 32'(e_out[k]));
    check($sformatf("ic_idx@%0d", k), 32'(ic_idx), 32'(e_ic[k]));
    check($sformatf("oc_idx@%0d", k), 32'(oc_idx), 32'(e_oc[k]));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_state"}, 32'(current_state), 0);
    check({tag, "_rdy"}, 32'(bus.pix_ready), 0);
    check({tag, "_strobes"}, 32'({buff_len_rst, win_valid, adder_rst, out_valid}), 0);
  endtask

  task automatic mark_busy(input int t, input int st, input int i, input int o);
    e_busy[t] = 1'b1;
    e_st[t]   = st;
    e_ic[t]   = i;
    e_oc[t]   = o;
  endtask

  task automatic run_layer(input int rl, input int rws, input int icg, input int ocg,
                           input int md, input int pct, input bit abrt);
    int t, endc, abort_at, md_eff, p2_start, npass;
    md_eff = (md == 0) ? 1 : md;
    for (int k = 0; k < MAXC; k++) begin
      e_rdy[k] = 0; e_br[k] = 0; e_win[k] = 0; e_adr[k] = 0; e_out[k] = 0;
      e_busy[k] = 0; e_done[k] = 0; e_st[k] = 0; e_ic[k] = 0; e_oc[k] = 0;
      e_blc[k] = (k == 0) ? blc_prev : rl;
      pv[k] = ($urandom_range(99) < pct);
    end
    t = 1; p2_start = 2; npass = 0;
    for (int o = 0; o < ocg; o++) begin
      for (int i = 0; i < icg; i++) begin
        if (npass == 1) p2_start = t;
        npass++;
        mark_busy(t, md_eff, i, o);
        e_br[t] = 1'b1;
        t++;
        for (int p = 0; p < rl * rws; p++) begin
          while (!pv[t] && t < MAXC - 16) begin
            mark_busy(t, md_eff, i, o);
            e_rdy[t] = 1'b1;
            t++;
          end
          mark_busy(t, md_eff, i, o);
          e_rdy[t] = 1'b1;
          if (p / rl >= 2 && p % rl >= 2) begin
            e_win[t + 1] = 1'b1;
            if (i == 0) e_adr[t + 1 + M] = 1'b1;
            if (i == icg - 1) e_out[t + 2 + M] = 1'b1;
          end
          t++;
        end
      end
    end
    for (int d = 0; d < M + 2; d++) begin
      mark_busy(t, md_eff, icg - 1, ocg - 1);
      t++;
    end
    e_done[t] = 1'b1; e_ic[t] = icg - 1; e_oc[t] = ocg - 1;
    endc = t + 3;
    abort_at = -1;
    if (abrt) begin
      abort_at = p2_start + 4;
      for (int k = abort_at + 1; k < endc; k++) begin
        e_rdy[k] = 0; e_br[k] = 0; e_win[k] = 0; e_adr[k] = 0; e_out[k] = 0;
        e_busy[k] = 0; e_done[k] = 0; e_st[k] = 0; e_ic[k] = 0; e_oc[k] = 0; e_blc[k] = 0;
      end
      endc = abort_at + 4;
    end

    c_x = 0; c_win = 0; c_adr = 0; c_out = 0; c_br = 0; last_x = -1; done_at = -1;
    for (int k = 0; k < endc; k++) begin
      @(negedge clk);
      check_cycle(k);
      if (win_valid) c_win++;
      if (adder_rst) c_adr++;
      if (out_valid) c_out++;
      if (buff_len_rst) c_br++;
      if (done) done_at = k;
      state_rst     = (k == abort_at);
      bus.start     = (k == 0) || (k == abort_at) || (e_busy[k] && $urandom_range(3) == 0);
      bus.cfg_mode  = (k == 0) ? 2'(md) : 2'($urandom_range(3));
      bus.cfg_row_len = (k == 0) ? RW'(rl) : RW'($urandom_range(511));
      bus.cfg_rows    = (k == 0) ? RW'(rws) : RW'($urandom_range(511));
      bus.cfg_ic_grp  = (k == 0) ? GW'(icg) : GW'($urandom_range(63));
      bus.cfg_oc_grp  = (k == 0) ? GW'(ocg) : GW'($urandom_range(63));
      bus.pix_valid = pv[k];
      if (pv[k] && bus.pix_ready) begin
        c_x++;
        last_x = k;
      end
    end
    state_rst = 1'b0;
    bus.start = 1'b0;
    blc_prev  = abrt ? 0 : rl;
  endtask

  initial begin
    rst = 1'b1; state_rst = 1'b0;
    bus.start = 1'b1; bus.cfg_mode = 2'd2;
    bus.cfg_row_len = RW'(5); bus.cfg_rows = RW'(4);
    bus.cfg_ic_grp = GW'(1); bus.cfg_oc_grp = GW'(1);
    bus.pix_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("reset");
      check("reset_blc", 32'(buff_len_ctrl), 0);
      check("reset_idx", 32'({ic_idx, oc_idx}), 0);
    end
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");

    // single pass, mode B, continuous valid
    run_layer(5, 4, 1, 1, 2, 100, 1'b0);
    check("sp_xfers", c_x, 20);
    check("sp_win", c_win, 6);
    check("sp_adr", c_adr, 6);
    check("sp_out", c_out, 6);
    check("sp_done_gap", done_at - last_x, 5);

    // 2x2 groups, continuous valid then 50% valid
    for (int pass = 0; pass < 2; pass++) begin
      run_layer(5, 4, 2, 2, 1, (pass == 0) ? 100 : 50, 1'b0);
      check("mg_br", c_br, 4);
      check("mg_xfers", c_x, 80);
      check("mg_win", c_win, 24);
      check("mg_adr", c_adr, 12);
      check("mg_out", c_out, 12);
      check("mg_done_gap", done_at - last_x, 5);
    end

    // illegal configurations never leave IDLE
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.cfg_mode = 2'd3;
      bus.cfg_row_len = RW'((c == 0) ? 2 : 6);
      bus.cfg_rows    = RW'((c == 1) ? 2 : 6);
      bus.cfg_ic_grp  = GW'((c == 2) ? 0 : 2);
      bus.cfg_oc_grp  = GW'((c == 3) ? 0 : 2);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        bus.start = 1'b0;
        check_quiet($sformatf("illegal%0d", c));
      end
    end

    // abort mid second pass, then a clean layer
    run_layer(6, 5, 2, 1, 3, 70, 1'b1);
    check("abort_no_done", done_at, -1);
    run_layer(6, 5, 1, 2, 0, 60, 1'b0);
    check("post_abort_out", c_out, 24);

    for (int r = 0; r < 6; r++) begin
      int rl, rws, icg, ocg;
      rl  = $urandom_range(8, 3);
      rws = $urandom_range(6, 3);
      icg = $urandom_range(3, 1);
      ocg = $urandom_range(2, 1);
      run_layer(rl, rws, icg, ocg, $urandom_range(3), $urandom_range(100, 30), 1'b0);
      check("rnd_win", c_win, (rl - 2) * (rws - 2) * icg * ocg);
      check("rnd_out", c_out, (rl - 2) * (rws - 2) * ocg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
